// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one RAM between requesters A and B.
// After reset it writes zero to every RAM word. It then grants one
// access per cycle, round-robin, and returns read data with a
// per-requester valid one cycle after the read grant.
module ram_rr_arbiter #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_SIZE = 10,
    parameter int INIT_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [MEM_WIDTH-1:0] wdata_a,
    output logic                 gnt_a,
    output logic                 rvalid_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [MEM_WIDTH-1:0] wdata_b,
    output logic                 gnt_b,
    output logic                 rvalid_b,
    output logic [MEM_WIDTH-1:0] rdata,
    output logic                 init_done,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0] ram_addr_wr,
    output logic [ADDR_SIZE-1:0] ram_addr_rd,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    input  logic [MEM_WIDTH-1:0] ram_dout
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {REQ_A, REQ_B} req_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    state_t                 state;
    state_t                 state_next;
    req_t                   last_gnt;
    logic [ADDR_SIZE-1:0]   init_addr;

    // The sweep is over exactly when the controller is in RUN.
    assign init_done = (state == ST_RUN);

    // Read data comes straight from the RAM's output register.
    assign rdata = ram_dout;

    // State, sweep address, round-robin history and read-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (INIT_EN != 0) begin
                state <= ST_INIT;
            end else begin
                state <= ST_RUN;
            end
            init_addr <= '0;
            last_gnt  <= REQ_B;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_addr <= init_addr + ADDR_SIZE'(1);
            end
            if (gnt_a) begin
                last_gnt <= REQ_A;
            end else if (gnt_b) begin
                last_gnt <= REQ_B;
            end
            rvalid_a <= gnt_a & ~we_a;
            rvalid_b <= gnt_b & ~we_b;
        end
    end

    // Next state, arbitration and RAM port drive.
    always_comb begin
        state_next     = state;
        gnt_a          = 1'b0;
        gnt_b          = 1'b0;
        ram_blk_select = 1'b0;
        ram_wr_en      = 1'b0;
        ram_rd_en      = 1'b0;
        ram_addr_wr    = '0;
        ram_addr_rd    = '0;
        ram_din        = '0;
        case (state)
            ST_INIT: begin
                ram_blk_select = 1'b1;
                ram_wr_en      = 1'b1;
                ram_addr_wr    = init_addr;
                if (init_addr == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // On contention the requester that did not win last goes.
                if (req_a && (!req_b || last_gnt == REQ_B)) begin
                    gnt_a = 1'b1;
                end else if (req_b) begin
                    gnt_b = 1'b1;
                end
                if (gnt_a) begin
                    ram_blk_select = 1'b1;
                    ram_wr_en      = we_a;
                    ram_rd_en      = ~we_a;
                    ram_addr_wr    = addr_a;
                    ram_addr_rd    = addr_a;
                    ram_din        = wdata_a;
                end else if (gnt_b) begin
                    ram_blk_select = 1'b1;
                    ram_wr_en      = we_b;
                    ram_rd_en      = ~we_b;
                    ram_addr_wr    = addr_b;
                    ram_addr_rd    = addr_b;
                    ram_din        = wdata_b;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed stimulus, a memory-level model checked
// every cycle, and a few literal expectations per scenario.
module tb_ram_rr_arbiter;

    localparam int W     = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [W-1:0]  wdata_a = '0, wdata_b = '0;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
    logic [W-1:0]  rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr_wr, ram_addr_rd;
    logic          ram_wr_en, ram_rd_en, ram_blk_select;

    // second instance, no clear sweep, small memory
    logic          req_b2 = 1'b1, we_b2 = 1'b1;
    logic [3:0]    addr_b2 = 4'd7;
    logic          gnt_a2, gnt_b2, rvalid_a2, rvalid_b2, init_done2;
    logic [W-1:0]  rdata2, ram_din2;
    logic [3:0]    ram_addr_wr2, ram_addr_rd2;
    logic          ram_wr_en2, ram_rd_en2, ram_blk_select2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(DEPTH), .ADDR_SIZE(AW), .INIT_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b),
        .rdata(rdata), .init_done(init_done),
        .ram_din(ram_din), .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
        .ram_dout(ram_dout)
    );

    ram_rr_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(16), .ADDR_SIZE(4), .INIT_EN(0)) dut2 (
        .clk(clk), .rst(rst),
        .req_a(1'b0), .we_a(1'b0), .addr_a(4'd0), .wdata_a(16'h0),
        .gnt_a(gnt_a2), .rvalid_a(rvalid_a2),
        .req_b(req_b2), .we_b(we_b2), .addr_b(addr_b2), .wdata_b(16'h5A5A),
        .gnt_b(gnt_b2), .rvalid_b(rvalid_b2),
        .rdata(rdata2), .init_done(init_done2),
        .ram_din(ram_din2), .ram_addr_wr(ram_addr_wr2), .ram_addr_rd(ram_addr_rd2),
        .ram_wr_en(ram_wr_en2), .ram_rd_en(ram_rd_en2), .ram_blk_select(ram_blk_select2),
        .ram_dout(16'h0)
    );

    // RAM behind the first instance: synchronous write, registered read
    logic [W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_blk_select && ram_wr_en) mem[ram_addr_wr] <= ram_din;
        if (ram_blk_select && ram_rd_en) ram_dout <= mem[ram_addr_rd];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick_a(input bit ra, input bit rb, input bit last_was_a);
        return ra && (!rb || !last_was_a);
    endfunction

    // ---------------- model: memory contents and pending read ------------
    logic [W-1:0] shadow [0:DEPTH-1];
    bit           m_init;
    int           m_cnt;
    bit           m_last_a;
    bit           m_pend_a, m_pend_b;
    logic [W-1:0] m_pend_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_init   <= 1'b1;
            m_cnt    <= 0;
            m_last_a <= 1'b0;
            m_pend_a <= 1'b0;
            m_pend_b <= 1'b0;
        end else if (m_init) begin
            shadow[m_cnt] <= '0;
            if (m_cnt == DEPTH - 1) m_init <= 1'b0;
            m_cnt    <= m_cnt + 1;
            m_pend_a <= 1'b0;
            m_pend_b <= 1'b0;
        end else begin
            m_pend_a <= 1'b0;
            m_pend_b <= 1'b0;
            if (pick_a(req_a, req_b, m_last_a)) begin
                m_last_a <= 1'b1;
                if (we_a) shadow[addr_a] <= wdata_a;
                else begin
                    m_pend_a    <= 1'b1;
                    m_pend_data <= shadow[addr_a];
                end
            end else if (req_b) begin
                m_last_a <= 1'b0;
                if (we_b) shadow[addr_b] <= wdata_b;
                else begin
                    m_pend_b    <= 1'b1;
                    m_pend_data <= shadow[addr_b];
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!rst) begin
            bit ea, eb;
            ea = !m_init && pick_a(req_a, req_b, m_last_a);
            eb = !m_init && !ea && req_b;
            check("gnt", {gnt_a, gnt_b}, {ea, eb});
            check("init_done", init_done, !m_init);
            if (m_init) begin
                check("init_ctrl", {ram_blk_select, ram_wr_en, ram_rd_en}, 3'b110);
                check("init_addr", ram_addr_wr, m_cnt);
                check("init_din", ram_din, 0);
            end else if (ea || eb) begin
                check("acc_ctrl", {ram_blk_select, ram_wr_en, ram_rd_en},
                      {1'b1, ea ? we_a : we_b, ea ? !we_a : !we_b});
                check("acc_addr_wr", ram_addr_wr, ea ? addr_a : addr_b);
                check("acc_addr_rd", ram_addr_rd, ea ? addr_a : addr_b);
                check("acc_din", ram_din, ea ? wdata_a : wdata_b);
            end else begin
                check("idle_bus", {ram_blk_select, ram_wr_en, ram_rd_en,
                                   ram_addr_wr, ram_addr_rd, ram_din}, 0);
            end
            check("rvalid", {rvalid_a, rvalid_b}, {m_pend_a, m_pend_b});
            if (m_pend_a || m_pend_b) check("rdata", rdata, m_pend_data);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic string gchar();
        if (gnt_a && gnt_b) return "2";
        if (gnt_a) return "A";
        if (gnt_b) return "B";
        return "-";
    endfunction

    initial begin
        int    wr_cycles;
        int    last_addr;
        bit    done;
        string seq;

        // 1: reset, sweep with req_a pending; 6: INIT_EN=0 instance
        req_a  = 1'b1; we_a = 1'b0; addr_a = 10'd5;
        @(negedge clk);
        check("t6_init_done_in_reset", init_done2, 1);
        cyc();
        rst = 1'b0;
        wr_cycles = 0; last_addr = -1; done = 1'b0;
        for (int i = 0; i < 1100 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("t6_init_done", init_done2, 1);
                check("t6_first_gnt_b", {gnt_a2, gnt_b2}, 2'b01);
                check("t6_first_write", {ram_wr_en2, ram_addr_wr2}, {1'b1, 4'd7});
            end
            if (init_done) begin
                done = 1'b1;
                check("t1_first_run_gnt_a", gnt_a, 1);
            end else begin
                if (ram_wr_en && ram_din == 0 && ram_addr_wr == AW'(wr_cycles))
                    wr_cycles++;
                last_addr = ram_addr_wr;
            end
        end
        req_b2 = 1'b0;
        check("t1_sweep_done", done, 1);
        check("t1_sweep_cycles", wr_cycles, 1024);
        check("t1_last_sweep_addr", last_addr, 1023);

        // 2: write BEEF to 3, read 3, read 4
        cyc();
        we_a = 1'b1; addr_a = 10'd3; wdata_a = 16'hBEEF;
        cyc();
        we_a = 1'b0;
        cyc();
        addr_a = 10'd4;
        @(negedge clk);
        check("t2_rvalid_a", {rvalid_a, rvalid_b}, 2'b10);
        check("t2_rdata_beef", rdata, 16'hBEEF);
        cyc();
        req_a = 1'b0;
        @(negedge clk);
        check("t2_rvalid_a_2", rvalid_a, 1);
        check("t2_rdata_zero", rdata, 16'h0000);

        // 3: B writes 1234 to 4, then both read continuously
        cyc();
        req_b = 1'b1; we_b = 1'b1; addr_b = 10'd4; wdata_b = 16'h1234;
        cyc();
        we_b = 1'b0; req_a = 1'b1; addr_a = 10'd3;
        seq = "";
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq = {seq, gchar()};
            cyc();
        end
        check("t3_rvalid_b", rvalid_b, 1);
        check("t3_rdata_b", rdata, 16'h1234);
        if (seq != "ABAB") begin
            n_err++;
            $display("FAIL t3_grant_seq: got %s expected ABAB", seq);
        end
        n_vec++;

        // 4: only B for 3 cycles, then both
        req_a = 1'b0;
        seq = "";
        for (int i = 0; i < 5; i++) begin
            if (i == 3) req_a = 1'b1;
            @(negedge clk);
            seq = {seq, gchar()};
            cyc();
        end
        if (seq != "BBBAB") begin
            n_err++;
            $display("FAIL t4_grant_seq: got %s expected BBBAB", seq);
        end
        n_vec++;
        req_a = 1'b0; req_b = 1'b0;
        cyc();

        // 5: read granted, then reset before the next edge
        req_a = 1'b1; we_a = 1'b0; addr_a = 10'd3;
        @(negedge clk);
        check("t5_read_granted", gnt_a, 1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; req_a = 1'b0;
        @(negedge clk);
        check("t5_rvalid_dropped", {rvalid_a, rvalid_b}, 2'b00);
        check("t5_init_done_low", init_done, 0);
        check("t5_sweep_restart", {ram_wr_en, ram_addr_wr}, {1'b1, 10'd0});
        repeat (3) cyc();
        @(negedge clk);
        check("t5_sweep_progress", ram_addr_wr, 10'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
